// File: rtl/humidity_debounce.sv
// Humidity sensor input conditioning: two-flop synchronizer, counter-based
// debounce FSM, edge pulses and a saturating count of accepted wet events.
module humidity_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int EVT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_raw,
  input  logic             evt_clr,
  output logic             sensor_clean,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [EVT_W-1:0] evt_count
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  // Last count value before a candidate level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [EVT_W-1:0] EVT_ZERO = {EVT_W{1'b0}};
  localparam logic [EVT_W-1:0] EVT_ONE  = {{(EVT_W-1){1'b0}}, 1'b1};
  localparam logic [EVT_W-1:0] EVT_MAX  = {EVT_W{1'b1}};

  logic             s1_r;
  logic             s2_r;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             clean_r;
  logic             clean_nxt_s;
  logic             rise_r;
  logic             rise_nxt_s;
  logic             fall_r;
  logic             fall_nxt_s;
  logic [EVT_W-1:0] evt_r;
  logic [EVT_W-1:0] evt_nxt_s;

  // Two-flop synchronizer for the asynchronous sensor bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= sensor_raw;
      s2_r <= s1_r;
    end
  end

  // Debounce next state: a WAIT state commits only after an unbroken run of
  // equal samples; any reversal drops straight back to the stable state.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    clean_nxt_s = clean_r;
    rise_nxt_s  = 1'b0;
    fall_nxt_s  = 1'b0;
    case (state_r)
      STABLE_LOW: begin
        if (s2_r) begin
          state_nxt_s = WAIT_HIGH;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      WAIT_HIGH: begin
        if (!s2_r) begin
          state_nxt_s = STABLE_LOW;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = STABLE_HIGH;
          clean_nxt_s = 1'b1;
          rise_nxt_s  = 1'b1;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!s2_r) begin
          state_nxt_s = WAIT_LOW;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      WAIT_LOW: begin
        if (s2_r) begin
          state_nxt_s = STABLE_HIGH;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = STABLE_LOW;
          clean_nxt_s = 1'b0;
          fall_nxt_s  = 1'b1;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = STABLE_LOW;
        cnt_nxt_s   = CNT_ZERO;
        clean_nxt_s = 1'b0;
      end
    endcase
  end

  // Wet-event counter: clear has priority, increment saturates.
  always_comb begin
    if (evt_clr) begin
      evt_nxt_s = EVT_ZERO;
    end else if (rise_r && (evt_r != EVT_MAX)) begin
      evt_nxt_s = evt_r + EVT_ONE;
    end else begin
      evt_nxt_s = evt_r;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= STABLE_LOW;
      cnt_r   <= CNT_ZERO;
      clean_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      evt_r   <= EVT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      clean_r <= clean_nxt_s;
      rise_r  <= rise_nxt_s;
      fall_r  <= fall_nxt_s;
      evt_r   <= evt_nxt_s;
    end
  end

  assign sensor_clean = clean_r;
  assign rise_pulse   = rise_r;
  assign fall_pulse   = fall_r;
  assign evt_count    = evt_r;

endmodule

// File: tb/tb_humidity_debounce.sv
// Self-checking bench for humidity_debounce: a run-length model checked every
// cycle plus directed scenarios with literal expectations.
module tb_humidity_debounce;

  localparam int D     = 4;
  localparam int EVT_W = 3;
  localparam int EMAX  = (1 << EVT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             sensor_raw;
  logic             evt_clr;
  logic             sensor_clean;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [EVT_W-1:0] evt_count;

  int n_cmp  = 0;
  int n_fail = 0;
  bit started = 1'b0;
  int rise_seen = 0;
  int fall_seen = 0;

  // Model: s2 must differ from the clean level for D consecutive samples.
  bit m_s1, m_s2, m_clean, m_rise, m_fall;
  int m_evt, m_run;

  humidity_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(16), .EVT_W(EVT_W)) dut (
    .clk(clk), .reset(reset), .sensor_raw(sensor_raw), .evt_clr(evt_clr),
    .sensor_clean(sensor_clean), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .evt_count(evt_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model advanced on every clock edge.
  always @(posedge clk) begin
    if (!reset) begin
      m_s1 = 0; m_s2 = 0; m_clean = 0; m_rise = 0; m_fall = 0;
      m_evt = 0; m_run = 0;
    end else begin
      if (evt_clr) m_evt = 0;
      else if (m_rise && m_evt < EMAX) m_evt = m_evt + 1;
      m_rise = 0;
      m_fall = 0;
      if (m_s2 != m_clean) begin
        m_run = m_run + 1;
        if (m_run == D) begin
          m_clean = !m_clean;
          if (m_clean) m_rise = 1; else m_fall = 1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = sensor_raw;
    end
  end

  // Per-cycle comparison against the model, plus pulse tallies.
  always @(negedge clk) begin
    if (started) begin
      check("model_clean", int'(sensor_clean), int'(m_clean));
      check("model_rise", int'(rise_pulse), int'(m_rise));
      check("model_fall", int'(fall_pulse), int'(m_fall));
      check("model_evt", int'(evt_count), m_evt);
      check("pulse_excl", int'(rise_pulse & fall_pulse), 0);
      if (rise_pulse) rise_seen++;
      if (fall_pulse) fall_seen++;
    end
  end

  task automatic do_reset();
    reset = 1'b0; sensor_raw = 1'b0; evt_clr = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(3);
    rise_seen = 0;
    fall_seen = 0;
  endtask

  initial begin
    bit found;
    reset = 1'b0; sensor_raw = 1'b1; evt_clr = 1'b0;
    tick(1);
    started = 1'b1;

    // 1: reset held with input high, then release.
    tick(2);
    check("rst_clean", int'(sensor_clean), 0);
    check("rst_rise", int'(rise_pulse), 0);
    check("rst_evt", int'(evt_count), 0);
    reset = 1'b1;
    rise_seen = 0;
    tick(1);                       // capture edge E
    tick(4);                       // E+1..E+4
    check("s1_clean_early", int'(sensor_clean), 0);
    tick(1);                       // E+5
    check("s1_clean_on", int'(sensor_clean), 1);
    check("s1_rise_on", int'(rise_pulse), 1);
    tick(1);
    check("s1_rise_off", int'(rise_pulse), 0);
    check("s1_evt", int'(evt_count), 1);
    check("s1_rise_cnt", rise_seen, 1);

    // 2: three-cycle glitch is rejected.
    do_reset();
    sensor_raw = 1'b1; tick(3);
    sensor_raw = 1'b0; tick(10);
    check("s2_clean", int'(sensor_clean), 0);
    check("s2_rise_cnt", rise_seen, 0);
    check("s2_fall_cnt", fall_seen, 0);
    check("s2_evt", int'(evt_count), 0);

    // 3: steady high then steady low.
    do_reset();
    sensor_raw = 1'b1; tick(10);
    sensor_raw = 1'b0; tick(10);
    check("s3_rise_cnt", rise_seen, 1);
    check("s3_fall_cnt", fall_seen, 1);
    check("s3_evt", int'(evt_count), 1);
    check("s3_clean", int'(sensor_clean), 0);

    // 4: nine events saturate the counter, then clear.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      sensor_raw = 1'b1; tick(8);
      check("s4_evt", int'(evt_count), (i + 1 < 7) ? i + 1 : 7);
      sensor_raw = 1'b0; tick(8);
    end
    evt_clr = 1'b1; tick(1);
    evt_clr = 1'b0;
    check("s4_clr", int'(evt_count), 0);

    // 5: clear in the same cycle as the pending increment.
    do_reset();
    sensor_raw = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick(1);
      if (rise_pulse) found = 1'b1;
    end
    check("s5_rise_found", int'(found), 1);
    evt_clr = 1'b1; tick(1);
    evt_clr = 1'b0;
    check("s5_evt_clr", int'(evt_count), 0);
    tick(2);
    check("s5_evt_hold", int'(evt_count), 0);
    check("s5_clean", int'(sensor_clean), 1);

    // 6: reset two cycles into WAIT_HIGH discards progress.
    do_reset();
    sensor_raw = 1'b1;
    tick(4);                       // E..E+3: WAIT_HIGH entered at E+2
    reset = 1'b0; tick(2);
    check("s6_clean_rst", int'(sensor_clean), 0);
    reset = 1'b1;
    rise_seen = 0;
    tick(5);                       // new capture edge plus four
    check("s6_clean_early", int'(sensor_clean), 0);
    check("s6_rise_early", rise_seen, 0);
    tick(1);
    check("s6_clean_on", int'(sensor_clean), 1);
    check("s6_rise_on", int'(rise_pulse), 1);
    tick(2);
    check("s6_evt", int'(evt_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
